// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing for the VGA debug display scan generator.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/sig_delay.sv
// Enabled shift register of DLY stages with async active-low clear to a per-bit reset value.
module sig_delay #(
    parameter int             W       = 1,
    parameter int             DLY     = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DLY];

    // NOTE: these are flops, not RAM, so every stage is reset; the outputs must
    // come up at their inactive levels rather than whatever power-up left behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) stage[i] <= RST_VAL;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DLY-1];

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: stage-0 pixel coordinates plus sync/blank aligned to a PIPE_DLY-deep
// render pipeline. Define VGA_SCAN_TICK_EN to add the i_tick pixel-enable port.
module vga_scan_gen
    import vga_pkg::CNT_W;
#(
    parameter int H_VIS    = vga_pkg::H_VIS,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_VIS    = vga_pkg::V_VIS,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef VGA_SCAN_TICK_EN
    input  logic             i_tick,
`endif
    output logic [CNT_W-1:0] o_px_x,
    output logic [CNT_W-1:0] o_px_y,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_video_on,
    output logic             o_hsync,
    output logic             o_vsync
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_scan_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_dly_check
        $error("vga_scan_gen: PIPE_DLY must be in 1..8");
    end

    logic adv;
`ifdef VGA_SCAN_TICK_EN
    assign adv = i_tick;
`else
    assign adv = 1'b1;
`endif

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of
    // its neighbours; blocking = here would make v see an already-updated h.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h <= '0;
            v <= '0;
        end else if (adv) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    logic vis, hs, vs;
    assign vis = (int'(h) < H_VIS) && (int'(v) < V_VIS);
    assign hs  = (int'(h) >= HS_START) && (int'(h) < HS_END);
    assign vs  = (int'(v) >= VS_START) && (int'(v) < VS_END);

    // Bus order {video_on, hsync, vsync}; sync bits are stored at their pin level.
    localparam logic [2:0] DLY_RST = {1'b0, ~SYNC_POL, ~SYNC_POL};

    logic [2:0] dly_q;

    sig_delay #(
        .W       (3),
        .DLY     (PIPE_DLY),
        .RST_VAL (DLY_RST)
    ) u_sync_dly (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (adv),
        .d     ({vis, hs ^ ~SYNC_POL, vs ^ ~SYNC_POL}),
        .q     (dly_q)
    );

    assign o_video_on = dly_q[2];
    assign o_hsync    = dly_q[1];
    assign o_vsync    = dly_q[0];

    assign o_px_x = h;
    assign o_px_y = v;

    // Counters sit at (0,0) during reset, so the pulses are masked by reset to stay low there.
    assign o_line_start  = i_rst_n & adv & (h == '0);
    assign o_frame_start = i_rst_n & adv & (h == '0) & (v == '0);

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: arithmetic raster model checked every cycle plus directed
// literal checks. Vertical timing is shortened so whole frames fit in a short run.
module tb_vga_scan_gen;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 12;
    localparam int V_FP   = 3;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int PIPE   = 2;
    localparam int H_TOT  = 800;
    localparam int V_TOT  = 20;
    localparam int FRAME  = H_TOT * V_TOT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic       vo;
        logic       hs;
        logic       vs;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b1;
    bit         tick_div2 = 1'b0;
    logic [9:0] px_x, px_y;
    logic       line_start, frame_start, video_on, hsync, vsync;
    logic       adv_tb;

    int n_cmp = 0;
    int n_err = 0;
    int n_adv = 0;

    always #5 clk = ~clk;

`ifdef VGA_SCAN_TICK_EN
    assign adv_tb = tick;
`else
    assign adv_tb = 1'b1;
`endif

    vga_scan_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(1'b0), .PIPE_DLY(PIPE)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
`ifdef VGA_SCAN_TICK_EN
        .i_tick        (tick),
`endif
        .o_px_x        (px_x),
        .o_px_y        (px_y),
        .o_line_start  (line_start),
        .o_frame_start (frame_start),
        .o_video_on    (video_on),
        .o_hsync       (hsync),
        .o_vsync       (vsync)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
            if (n_err >= 100) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    endtask

    // Model: the n-th pixel advance since reset sits at (n mod H_TOT, n div H_TOT mod V_TOT);
    // sync/blank describe pixel n-PIPE, or idle levels before that pixel exists.
    function automatic exp_t model(input int n, input logic adv);
        exp_t e;
        int   x, y, dx, dy;
        x = n % H_TOT;
        y = (n / H_TOT) % V_TOT;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.ls = adv && (x == 0);
        e.fs = adv && (x == 0) && (y == 0);
        if (n < PIPE) begin
            e.vo = 1'b0;
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            dx = (n - PIPE) % H_TOT;
            dy = ((n - PIPE) / H_TOT) % V_TOT;
            e.vo = (dx < H_VIS) && (dy < V_VIS);
            e.hs = !((dx >= H_VIS + H_FP) && (dx < H_VIS + H_FP + H_SYNC));
            e.vs = !((dy >= V_VIS + V_FP) && (dy < V_VIS + V_FP + V_SYNC));
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_adv <= 0;
        else if (adv_tb) n_adv <= n_adv + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            e = model(n_adv, adv_tb);
            check("cyc_px_x", px_x, e.x);
            check("cyc_px_y", px_y, e.y);
            check("cyc_flags{ls,fs,vo,hs,vs}",
                  {line_start, frame_start, video_on, hsync, vsync},
                  {e.ls, e.fs, e.vo, e.hs, e.vs});
        end
    end

    // One clock: inputs change 2 units after the edge, main-flow sampling 4 units after.
    task automatic step();
        @(posedge clk);
        #2;
        if (tick_div2) tick = ~tick;
        #2;
    endtask

    task automatic wait_px(input int x, input int y, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (px_x == 10'(x) && px_y == 10'(y)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_px_x"}, px_x, 0);
        check({tag, "_px_y"}, px_y, 0);
        check({tag, "_line_start"}, line_start, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_video_on"}, video_on, 0);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
    endtask

    initial begin
        int lo, first_x, first_y, cnt, changes;
        logic [9:0] prev_x;
        bit ok;

        // Reset held, then released away from the edge.
        rst_n = 1'b0;
        tick  = 1'b1;
        repeat (3) step();
        check_reset_vals("in_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        #2;
        check("rel_px_x", px_x, 0);
        check("rel_px_y", px_y, 0);
        check("rel_frame_start", frame_start, 1);
        check("rel_line_start", line_start, 1);
        check("rel_hsync", hsync, 1);
        check("rel_vsync", vsync, 1);
        check("rel_video_on", video_on, 0);
        step();
        check("x1_video_on", video_on, 0);
        step();
        check("x2_px_x", px_x, 2);
        check("x2_video_on", video_on, 1);

        // Line wrap.
        repeat (797) step();
        check("eol_px_x", px_x, 799);
        check("eol_px_y", px_y, 0);
        check("eol_line_start", line_start, 0);
        step();
        check("wrap_px_x", px_x, 0);
        check("wrap_px_y", px_y, 1);
        check("wrap_line_start", line_start, 1);
        check("wrap_frame_start", frame_start, 0);

        // Hsync window across line 1.
        lo = 0;
        first_x = -1;
        repeat (H_TOT) begin
            if (!hsync) begin
                if (first_x < 0) first_x = int'(px_x);
                lo++;
            end
            step();
        end
        check("hs_low_cycles", lo, 96);
        check("hs_first_low_x", first_x, 658);

        // Full frame from (0,0): vsync window and frame wrap.
        wait_px(0, 0, FRAME + 10, ok);
        check("reach_frame_start", ok, 1);
        lo = 0;
        first_x = -1;
        first_y = -1;
        repeat (FRAME) begin
            if (!vsync) begin
                if (first_x < 0) begin
                    first_x = int'(px_x);
                    first_y = int'(px_y);
                end
                lo++;
            end
            step();
        end
        check("vs_low_cycles", lo, 1600);
        check("vs_first_low_x", first_x, 2);
        check("vs_first_low_y", first_y, 15);
        check("fwrap_px_x", px_x, 0);
        check("fwrap_px_y", px_y, 0);
        check("fwrap_frame_start", frame_start, 1);

        // Asynchronous reset mid-line.
        wait_px(300, 5, 6 * H_TOT, ok);
        check("reach_300_5", ok, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (3) step();
        check_reset_vals("held_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        #2;
        check("restart_px_x", px_x, 0);
        check("restart_px_y", px_y, 0);
        check("restart_frame_start", frame_start, 1);

`ifdef VGA_SCAN_TICK_EN
        // Pixel enable every second clock: frame period doubles.
        tick_div2 = 1'b1;
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step();
            cnt++;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("tick_frame_seen", ok, 1);
        check("tick_frame_clocks", cnt, 2 * FRAME);

        changes = 0;
        prev_x  = px_x;
        repeat (20) begin
            step();
            if (px_x != prev_x) changes++;
            prev_x = px_x;
        end
        check("tick_x_steps_in_20", changes, 10);

        wait_px(100, 0, 500, ok);
        check("reach_x100", ok, 1);
        tick_div2 = 1'b0;
        tick      = 1'b0;
        repeat (50) step();
        check("frozen_px_x", px_x, 100);
        check("frozen_hsync", hsync, 1);
        check("frozen_line_start", line_start, 0);
        tick = 1'b1;
        step();
        check("resume_px_x", px_x, 101);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
